// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU path (A) and the
// long-latency path (B), with a busy scoreboard. Optional B starvation guard: WB_STARVE_GUARD_EN.
module rf_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  input  logic [AW-1:0]      a_rdc,
  input  logic [DW-1:0]      a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [AW-1:0]      b_rdc,
  input  logic [DW-1:0]      b_data,
  output logic               b_ready,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_rdc,
  input  logic [AW-1:0]      chk_rsc,
  input  logic [AW-1:0]      chk_rtc,
  output logic               hazard,
  output logic [(1<<AW)-1:0] busy,
  output logic               RF_w,
  output logic [AW-1:0]      rdc,
  output logic [DW-1:0]      rd
);

  localparam int NREG = 1 << AW;

  logic            force_b;
  logic [NREG-1:0] busy_nxt;

  // A is held off while its destination still has an older B write pending.
  assign a_ready = a_valid && !busy[a_rdc] && !force_b;
  assign b_ready = b_valid && !a_ready;
  assign hazard  = busy[chk_rsc] | busy[chk_rtc];

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign force_b = b_valid && (starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!b_valid || b_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict A priority; the comparison is always false and only ties off the parameter.
  assign force_b = (STARVE_MAX < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RF_w <= 1'b0;
      rdc  <= '0;
      rd   <= '0;
    end else if (a_ready) begin
      RF_w <= (a_rdc != '0);
      rdc  <= a_rdc;
      rd   <= a_data;
    end else if (b_ready) begin
      RF_w <= (b_rdc != '0);
      rdc  <= b_rdc;
      rd   <= b_data;
    end else begin
      RF_w <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle re-reservation keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (b_ready) busy_nxt[b_rdc] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_rdc] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expectations are hand-computed.
// Starvation expectations follow WB_STARVE_GUARD_EN.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic [AW-1:0] a_rdc;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_rdc;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          rsv_valid;
  logic [AW-1:0] rsv_rdc;
  logic [AW-1:0] chk_rsc;
  logic [AW-1:0] chk_rtc;
  logic          hazard;
  logic [31:0]   busy;
  logic          RF_w;
  logic [AW-1:0] rdc;
  logic [DW-1:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rdc(a_rdc), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rdc(b_rdc), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_rdc(rsv_rdc),
    .chk_rsc(chk_rsc), .chk_rtc(chk_rtc), .hazard(hazard),
    .busy(busy), .RF_w(RF_w), .rdc(rdc), .rd(rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rdc = '0; a_data = '0;
    b_valid = 0; b_rdc = '0; b_data = '0;
    rsv_valid = 0; rsv_rdc = '0;
    chk_rsc = '0; chk_rtc = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    check("rst_rf_w", RF_w, 0);
    check("rst_rdc", rdc, 0);
    check("rst_rd", rd, 0);
    check("rst_busy", busy, 0);

    // A only
    a_valid = 1; a_rdc = 3; a_data = 32'h1234;
    #1;
    check("a_only_a_ready", a_ready, 1);
    check("a_only_b_ready", b_ready, 0);
    tick();
    check("a_only_rf_w", RF_w, 1);
    check("a_only_rdc", rdc, 3);
    check("a_only_rd", rd, 32'h1234);
    a_valid = 0;
    tick();
    check("a_only_rf_w_drop", RF_w, 0);
    check("a_only_rdc_hold", rdc, 3);
    check("a_only_rd_hold", rd, 32'h1234);

    // Contention: A first, then B
    a_valid = 1; a_rdc = 4; a_data = 32'hAAAA;
    b_valid = 1; b_rdc = 7; b_data = 32'hBBBB;
    #1;
    check("cont_a_ready", a_ready, 1);
    check("cont_b_ready", b_ready, 0);
    tick();
    check("cont_rdc_a", rdc, 4);
    check("cont_rd_a", rd, 32'hAAAA);
    a_valid = 0;
    #1;
    check("cont_b_ready2", b_ready, 1);
    tick();
    check("cont_rf_w_b", RF_w, 1);
    check("cont_rdc_b", rdc, 7);
    check("cont_rd_b", rd, 32'hBBBB);
    b_valid = 0;

    // Scoreboard and WAW guard
    rsv_valid = 1; rsv_rdc = 9;
    tick();
    rsv_valid = 0;
    check("sb_busy9", busy, 32'h0000_0200);
    chk_rsc = 9; chk_rtc = 2;
    #1 check("sb_hazard_rs", hazard, 1);
    chk_rsc = 2; chk_rtc = 9;
    #1 check("sb_hazard_rt", hazard, 1);
    chk_rsc = 2; chk_rtc = 3;
    #1 check("sb_no_hazard", hazard, 0);
    a_valid = 1; a_rdc = 9; a_data = 32'h9999;
    #1 check("waw_a_stall", a_ready, 0);
    tick();
    check("waw_no_write", RF_w, 0);
    b_valid = 1; b_rdc = 9; b_data = 32'h5555; chk_rsc = 9;
    #1;
    check("waw_a_still_stalled", a_ready, 0);
    check("waw_b_ready", b_ready, 1);
    tick();
    check("waw_b_rf_w", RF_w, 1);
    check("waw_b_rdc", rdc, 9);
    check("waw_b_rd", rd, 32'h5555);
    check("waw_busy_clear", busy, 0);
    check("waw_hazard_clear", hazard, 0);
    b_valid = 0;
    #1 check("waw_a_ready", a_ready, 1);
    tick();
    check("waw_a_rdc", rdc, 9);
    check("waw_a_rd", rd, 32'h9999);
    a_valid = 0; chk_rsc = 0;

    // Same-cycle set and clear of r12: set wins
    rsv_valid = 1; rsv_rdc = 12;
    tick();
    check("sc_busy12", busy, 32'h0000_1000);
    b_valid = 1; b_rdc = 12; b_data = 32'hC0DE;
    #1 check("sc_b_ready", b_ready, 1);
    tick();
    check("sc_set_wins", busy, 32'h0000_1000);
    check("sc_rdc", rdc, 12);
    rsv_valid = 0;
    tick();
    check("sc_cleared", busy, 0);
    b_valid = 0;

    // r0 handling
    rsv_valid = 1; rsv_rdc = 0;
    tick();
    rsv_valid = 0;
    check("r0_not_busy", busy, 0);
    a_valid = 1; a_rdc = 0; a_data = 32'hFFFF_FFFF;
    #1 check("r0_a_ready", a_ready, 1);
    tick();
    check("r0_no_write", RF_w, 0);
    check("r0_rdc", rdc, 0);
    check("r0_rd", rd, 32'hFFFF_FFFF);
    a_valid = 0;

    // Reset mid-write, asynchronous
    a_valid = 1; a_rdc = 5; a_data = 32'h77;
    rsv_valid = 1; rsv_rdc = 20;
    tick();
    check("mid_rf_w", RF_w, 1);
    check("mid_rdc", rdc, 5);
    check("mid_busy20", busy, 32'h0010_0000);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    check("async_rf_w", RF_w, 0);
    check("async_rdc", rdc, 0);
    check("async_rd", rd, 0);
    check("async_busy", busy, 0);
    #1 rst_n = 1;
    tick();
    check("post_rst_rf_w", RF_w, 0);

    // Starvation under continuous A traffic
    a_valid = 1; a_rdc = 1; a_data = 32'h11;
    b_valid = 1; b_rdc = 2; b_data = 32'h22;
    for (int i = 0; i < 8; i++) begin
      logic exp_b;
`ifdef WB_STARVE_GUARD_EN
      exp_b = (i == 4);
`else
      exp_b = 1'b0;
`endif
      #1;
      check($sformatf("starve_b_ready_%0d", i), b_ready, exp_b);
      check($sformatf("starve_a_ready_%0d", i), a_ready, !exp_b);
      tick();
      check($sformatf("starve_rdc_%0d", i), rdc, exp_b ? 2 : 1);
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
